// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - SVGA 800x600@60 timing constants and phase type
package video_timing_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 40;
    localparam int H_SYNC   = 128;
    localparam int H_BP     = 88;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 600;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 4;
    localparam int V_BP     = 23;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int H_W = 11;
    localparam int V_W = 10;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

endpackage

// File: rtl/video_timing_if.sv
// rtl/video_timing_if.sv - raster timing bundle from the generator to the shader stage
interface video_timing_if #(
    parameter int TIMER_W = 16
);
    import video_timing_pkg::*;

    logic [H_W-1:0]     hcount;
    logic [V_W-1:0]     vcount;
    logic               enable;
    logic               hsync;
    logic               vsync;
    logic               line_start;
    logic               frame_start;
    logic [TIMER_W-1:0] timer;

    modport master (
        output hcount, vcount, enable, hsync, vsync, line_start, frame_start, timer
    );

    modport slave (
        input hcount, vcount, enable, hsync, vsync, line_start, frame_start, timer
    );

endinterface

// File: rtl/sync_axis_counter.sv
// rtl/sync_axis_counter.sv - one raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM
module sync_axis_counter
    import video_timing_pkg::*;
#(
    parameter int ACT_LEN  = 800,
    parameter int FP_LEN   = 40,
    parameter int SYNC_LEN = 128,
    parameter int BP_LEN   = 88,
    parameter int W        = 11
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         advance,
    output logic [W-1:0] count,
    output phase_t       phase,
    output logic         in_sync,
    output logic         wrap
);

    localparam int TOTAL = ACT_LEN + FP_LEN + SYNC_LEN + BP_LEN;
    localparam logic [W-1:0] ACT_END  = W'(ACT_LEN - 1);
    localparam logic [W-1:0] FP_END   = W'(ACT_LEN + FP_LEN - 1);
    localparam logic [W-1:0] SYNC_END = W'(ACT_LEN + FP_LEN + SYNC_LEN - 1);
    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);

    logic [W-1:0] count_q, count_d;
    phase_t       phase_q, phase_d;
    logic         in_sync_q, in_sync_d;

    // Combinational so the next axis can advance on the same pix_ce.
    assign wrap = advance && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (advance) begin
            count_d = wrap ? '0 : count_q + 1'b1;
            case (phase_q)
                ACTIVE:  if (count_q == ACT_END)  phase_d = FRONT;
                FRONT:   if (count_q == FP_END)   phase_d = SYNC;
                SYNC:    if (count_q == SYNC_END) phase_d = BACK;
                BACK:    if (count_q == LAST)     phase_d = ACTIVE;
                default: phase_d = BACK;
            endcase
        end
        in_sync_d = (phase_d == SYNC);
    end

    // Reset parks on the last position so the first advance lands on 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= LAST;
            phase_q   <= BACK;
            in_sync_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            phase_q   <= phase_d;
            in_sync_q <= in_sync_d;
        end
    end

    assign count   = count_q;
    assign phase   = phase_q;
    assign in_sync = in_sync_q;

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator: h/v counters, syncs, enable, pulses and frame timer
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = video_timing_pkg::H_ACTIVE,
    parameter int H_FP     = video_timing_pkg::H_FP,
    parameter int H_SYNC   = video_timing_pkg::H_SYNC,
    parameter int H_BP     = video_timing_pkg::H_BP,
    parameter int V_ACTIVE = video_timing_pkg::V_ACTIVE,
    parameter int V_FP     = video_timing_pkg::V_FP,
    parameter int V_SYNC   = video_timing_pkg::V_SYNC,
    parameter int V_BP     = video_timing_pkg::V_BP,
    parameter int SYNC_POL = 1,
    parameter int TIMER_W  = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            pix_ce,
    input  logic            timer_hold,
    video_timing_if.master  vt
);

    localparam logic           POL     = (SYNC_POL != 0);
    localparam logic [V_W-1:0] V_ENTRY = V_W'(V_ACTIVE + V_FP - 1);

    logic [H_W-1:0] h_count;
    logic [V_W-1:0] v_count;
    phase_t         h_phase, v_phase;
    logic           h_in_sync, v_in_sync;
    logic           h_wrap, v_wrap;
    logic           v_adv;
    logic           timer_inc;

    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    assign v_adv = pix_ce && h_wrap;

    sync_axis_counter #(
        .ACT_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP), .W(H_W)
    ) u_h_axis (
        .clock   (clock),
        .reset_n (reset_n),
        .advance (pix_ce),
        .count   (h_count),
        .phase   (h_phase),
        .in_sync (h_in_sync),
        .wrap    (h_wrap)
    );

    sync_axis_counter #(
        .ACT_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP), .W(V_W)
    ) u_v_axis (
        .clock   (clock),
        .reset_n (reset_n),
        .advance (v_adv),
        .count   (v_count),
        .phase   (v_phase),
        .in_sync (v_in_sync),
        .wrap    (v_wrap)
    );

    // Timer steps on the line move into vertical sync, keeping it fixed across active video.
    assign timer_inc = v_adv && (v_count == V_ENTRY);

    always_comb begin
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        timer_d       = timer_q;
        if (pix_ce) begin
            line_start_d  = h_wrap;
            frame_start_d = h_wrap && v_wrap;
            if (timer_inc && !timer_hold) begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            timer_q       <= '0;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            timer_q       <= timer_d;
        end
    end

    assign vt.hcount      = h_count;
    assign vt.vcount      = v_count;
    assign vt.enable      = (h_phase == ACTIVE) && (v_phase == ACTIVE);
    assign vt.hsync       = h_in_sync ? POL : ~POL;
    assign vt.vsync       = v_in_sync ? POL : ~POL;
    assign vt.line_start  = line_start_q;
    assign vt.frame_start = frame_start_q;
    assign vt.timer       = timer_q;

endmodule
